// File: rtl/isram_rd_slave.sv
// Read-only AXI4-Lite responder for instruction memory: one read at a time,
// fixed or LFSR-driven response latency, plus a side-band preload port.
module isram_rd_slave #(
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          DEPTH    = 1024,
  parameter bit          RAND_LAT = 1'b0,
  parameter int          FIX_LAT  = 0,
  parameter int          LAT_W    = 3,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LAT_W > 4) ? LAT_W : 4;

  // Range bounds held in 33 bits so BASE + 4*DEPTH cannot wrap past 2^32.
  localparam logic [32:0] RANGE_LO = {1'b0, BASE};
  localparam logic [32:0] RANGE_HI = {1'b0, BASE} + 33'(4 * DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // AR and R channels obey AXI valid/ready: a beat transfers on an edge where
  // both valid and ready are high; a raised valid with its payload holds until
  // that edge. arready is high only in IDLE, rvalid only in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        lfsr;
  logic [31:0]       addr_q;
  logic [31:0]       mem [DEPTH];

  logic              lfsr_fb;
  logic [CNT_W-1:0]  lat_l;
  logic [32:0]       addr_x;
  logic [AW-1:0]     idx;
  logic [1:0]        resp_d;

  // Fibonacci taps 8,6,5,4 (bits 7,5,4,3), shifted left into bit 0.
  always_comb begin
    lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // LAT_W is expected to be at most 8, the width of the LFSR.
  always_comb begin
    if (RAND_LAT) begin
      lat_l = CNT_W'(lfsr[LAT_W-1:0]);
    end else begin
      lat_l = CNT_W'(FIX_LAT);
    end
  end

  // Decode of the latched address; misalignment wins over out-of-range.
  always_comb begin
    addr_x = {1'b0, addr_q};
    idx    = AW'((addr_q - BASE) >> 2);
    if (addr_q[1:0] != 2'b00) begin
      resp_d = RESP_SLVERR;
    end else if ((addr_x < RANGE_LO) || (addr_x >= RANGE_HI)) begin
      resp_d = RESP_DECERR;
    end else begin
      resp_d = RESP_OKAY;
    end
  end

  // Preload port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      cnt     <= '0;
      lfsr    <= SEED;
      addr_q  <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (arvalid && arready) begin
            addr_q  <= araddr;
            cnt     <= lat_l;
            arready <= 1'b0;
            state   <= WAIT;
          end else begin
            arready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            // Non-blocking read: a load landing on this same edge is not seen.
            rdata  <= (resp_d == RESP_OKAY) ? mem[idx] : 32'h0;
            rresp  <= resp_d;
            rvalid <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          arready <= 1'b0;
          rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isram_rd_slave.sv
// Bench for isram_rd_slave: three instances (zero latency, fixed latency 3,
// LFSR latency) driven in turn, responses checked against a scoreboard.
module tb_isram_rd_slave;

  localparam int          N    = 3;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] araddr  [N];
  logic        arvalid [N];
  wire         arready [N];
  wire  [31:0] rdata   [N];
  wire  [1:0]  rresp   [N];
  wire         rvalid  [N];
  logic        rready  [N];
  logic        ld_en   [N];
  logic [9:0]  ld_addr [N];
  logic [31:0] ld_data [N];

  int          n_cmp = 0;
  int          n_err = 0;

  logic [31:0] exp_q  [$];
  logic [1:0]  resp_q [$];
  logic [3:0]  lat_q  [$];
  logic [31:0] img    [N][16];
  logic [7:0]  m_lfsr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    isram_rd_slave #(
      .BASE     (BASE),
      .DEPTH    (1024),
      .RAND_LAT (g == 2),
      .FIX_LAT  ((g == 1) ? 3 : 0),
      .LAT_W    (3),
      .SEED     (8'hA5)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr[g]),
      .arvalid (arvalid[g]),
      .arready (arready[g]),
      .rdata   (rdata[g]),
      .rresp   (rresp[g]),
      .rvalid  (rvalid[g]),
      .rready  (rready[g]),
      .ld_en   (ld_en[g]),
      .ld_addr (ld_addr[g]),
      .ld_data (ld_data[g])
    );
  end

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, reset to the seed.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    logic [32:0] ax;
    ax = {1'b0, a};
    if (a[1:0] != 2'b00) return 2'd2;
    if (ax < {1'b0, BASE} || ax >= ({1'b0, BASE} + 33'd4096)) return 2'd3;
    return 2'd0;
  endfunction

  task automatic ld_word(input int d, input int idx, input logic [31:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = idx[9:0];
    ld_data[d] = v;
    @(negedge clk);
    ld_en[d]   = 1'b0;
    img[d][idx] = v;
  endtask

  task automatic wait_arready(input int d);
    int t;
    t = 0;
    while (!arready[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ar_wait", 32'(arready[d]), 32'd1);
  endtask

  // Address handshake only; used where the transaction is later dropped by reset.
  task automatic start_read(input int d, input logic [31:0] a);
    wait_arready(d);
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    rready[d]  = 1'b0;
    @(negedge clk);
    arvalid[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [31:0] a, input int hold, input bit collide);
    int          t;
    logic [31:0] idx;
    logic [31:0] ed;
    logic [1:0]  er;
    logic [3:0]  el;
    logic [31:0] hd;
    logic [1:0]  hr;
    wait_arready(d);
    er  = ref_resp(a);
    idx = (a - BASE) >> 2;
    ed  = (er == 2'd0) ? img[d][idx[3:0]] : 32'h0;
    el  = (d == 2) ? {1'b0, m_lfsr[2:0]} : ((d == 1) ? 4'd3 : 4'd0);
    exp_q.push_back(ed);
    resp_q.push_back(er);
    lat_q.push_back(el);
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    rready[d]  = (hold == 0);
    @(negedge clk);
    arvalid[d] = 1'b0;
    check("ar_drop", 32'(arready[d]), 32'd0);
    if (collide) begin
      ld_en[d]   = 1'b1;
      ld_addr[d] = idx[9:0];
      ld_data[d] = ~ed;
    end
    t = 0;
    while (!rvalid[d] && t < 40) begin
      @(negedge clk);
      ld_en[d] = 1'b0;
      t++;
    end
    ld_en[d] = 1'b0;
    check("rvalid_seen", 32'(rvalid[d]), 32'd1);
    check("latency", 32'(t - 1), 32'(lat_q.pop_front()));
    check("rdata", rdata[d], exp_q.pop_front());
    check("rresp", 32'(rresp[d]), 32'(resp_q.pop_front()));
    hd = rdata[d];
    hr = rresp[d];
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        arvalid[d] = 1'b1;
        araddr[d]  = a ^ 32'h4;
        if (collide) begin
          ld_en[d]   = 1'b1;
          ld_data[d] = ed ^ 32'h5A5A_5A5A;
        end
      end
      @(negedge clk);
      ld_en[d] = 1'b0;
      check("hold_rvalid", 32'(rvalid[d]), 32'd1);
      check("hold_rdata", rdata[d], hd);
      check("hold_rresp", 32'(rresp[d]), 32'(hr));
      check("hold_arready", 32'(arready[d]), 32'd0);
    end
    arvalid[d] = 1'b0;
    rready[d]  = 1'b1;
    @(negedge clk);
    rready[d]  = 1'b0;
    check("done_rvalid", 32'(rvalid[d]), 32'd0);
    check("done_arready", 32'(arready[d]), 32'd1);
    if (collide) img[d][idx[3:0]] = (hold > 0) ? (ed ^ 32'h5A5A_5A5A) : ~ed;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < N; d++) begin
      araddr[d]  = '0;
      arvalid[d] = 1'b0;
      rready[d]  = 1'b0;
      ld_en[d]   = 1'b0;
      ld_addr[d] = '0;
      ld_data[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check("rst_arready", 32'(arready[d]), 32'd0);
      check("rst_rvalid", 32'(rvalid[d]), 32'd0);
      check("rst_rdata", rdata[d], 32'd0);
      check("rst_rresp", 32'(rresp[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N; d++) check("post_rst_arready", 32'(arready[d]), 32'd1);

    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 16; i++) begin
        ld_word(d, i, (i == 0) ? 32'h0000_0413 : ((i == 1) ? 32'h0010_0093 : $urandom));
      end
    end

    // Basic reads at latency 0 and 3, then backpressure.
    do_read(0, BASE, 0, 1'b0);
    do_read(1, BASE + 32'h4, 0, 1'b0);
    do_read(1, BASE + 32'h8, 5, 1'b0);
    do_read(0, BASE + 32'hC, 5, 1'b0);

    // Error decode.
    do_read(0, 32'h8000_0002, 0, 1'b0);
    do_read(0, 32'h8000_1000, 0, 1'b0);
    do_read(0, 32'h7FFF_FFFC, 0, 1'b0);
    do_read(0, 32'hFFFF_FFFE, 0, 1'b0);
    do_read(1, 32'h8000_0FFF, 2, 1'b0);
    do_read(1, 32'h8000_0FFC + 32'h4, 0, 1'b0);

    // Loads landing on the read edge and during RESP, then read back.
    do_read(0, BASE + 32'h10, 2, 1'b1);
    do_read(0, BASE + 32'h10, 0, 1'b0);
    do_read(0, BASE + 32'h14, 0, 1'b1);
    do_read(0, BASE + 32'h14, 1, 1'b0);

    // Random latency, random rready backpressure, back to back.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'(4 * $urandom_range(0, 15));
      if (r == 0)      a = a + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h7FFF_FFF0;
      else if (r == 2) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
      do_read(2, a, $urandom_range(0, 3), 1'b0);
    end

    // Reset while in WAIT.
    start_read(1, BASE + 32'h4);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_rvalid", 32'(rvalid[1]), 32'd0);
    check("rst_wait_arready", 32'(arready[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_rearm", 32'(arready[1]), 32'd1);
    check("rst_wait_nostale", 32'(rvalid[1]), 32'd0);
    do_read(1, BASE + 32'h4, 0, 1'b0);

    // Reset while in RESP.
    start_read(1, BASE + 32'h8);
    repeat (5) @(negedge clk);
    check("resp_pending", 32'(rvalid[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp_rvalid", 32'(rvalid[1]), 32'd0);
    check("rst_resp_arready", 32'(arready[1]), 32'd0);
    check("rst_resp_rdata", rdata[1], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_rearm", 32'(arready[1]), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_resp_nostale", 32'(rvalid[1]), 32'd0);
    do_read(1, BASE, 0, 1'b0);
    do_read(2, BASE + 32'h8, 0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
